// File: rtl/updown_counter_n.sv
// Parametrised up/down counter: sync load, programmable modulus, cascade via rco -> cas_in.
// Latency: q/wrap 1 cycle after the qualifying edge; max_min/rco are combinational.
// No backpressure; optional runtime saturation mode is enabled by defining UPDN_CNT_SAT_EN.
module updown_counter_n #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] MAX_VAL   = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cas_in,
    input  logic             down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`ifdef UPDN_CNT_SAT_EN
    input  logic             sat,
`endif
    output logic [WIDTH-1:0] q,
    output logic             max_min,
    output logic             rco,
    output logic             wrap
);

    logic             at_max;
    logic             at_min;
    logic             step;
    logic             sat_mode;
    logic [WIDTH-1:0] load_clamped;

`ifdef UPDN_CNT_SAT_EN
    assign sat_mode = sat;
`else
    assign sat_mode = 1'b0;
`endif

    assign at_max       = (q == MAX_VAL);
    assign at_min       = (q == '0);
    assign step         = en & cas_in;
    assign load_clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;

    // Terminal flag looks at the boundary in the current direction only.
    assign max_min = down ? at_min : at_max;
    assign rco     = max_min & step;

    always_ff @(posedge clk) begin
        if (rst) begin
            q    <= RESET_VAL;
            wrap <= 1'b0;
        end else if (load) begin
            q    <= load_clamped;
            wrap <= 1'b0;
        end else if (step) begin
            if (down) begin
                if (!at_min) begin
                    q    <= q - WIDTH'(1);
                    wrap <= 1'b0;
                end else if (sat_mode) begin
                    wrap <= 1'b0;
                end else begin
                    q    <= MAX_VAL;
                    wrap <= 1'b1;
                end
            end else begin
                if (!at_max) begin
                    q    <= q + WIDTH'(1);
                    wrap <= 1'b0;
                end else if (sat_mode) begin
                    wrap <= 1'b0;
                end else begin
                    q    <= '0;
                    wrap <= 1'b1;
                end
            end
        end else begin
            wrap <= 1'b0;
        end
    end

endmodule
